beat_note_scheduler: RTL
========================

// Module: beat_note_scheduler
// PURPOSE
//   Consumes the beatmap generator's data/data_en stream and turns it into timed note events.
//   - A local beat timer samples one code per beat.
//   - Each code is held in a delay FIFO for LEAD_BEATS beats, then released as a note event.
//   - Downstream, the lane renderer / hit judge sees a note exactly LEAD_BEATS beats after it was sampled.
// PARAMETERS
//   BEAT_CYCLES  50_000_000  clocks per beat; must be >= 2
//   LEAD_BEATS   4           beats between sampling a code and emitting it; 1..DEPTH-1
//   DEPTH        8           delay-FIFO entries; must be >= LEAD_BEATS+1
// PORTS
//   clk         in   1   system clock; all logic on posedge clk
//   resetn      in   1   synchronous, active-low reset
//   run         in   1   1 = schedule notes; 0 = hold timer and flush queue
//   data_en     in   1   generator output valid (level, no backpressure)
//   data        in   8   generator note code; 8'd0 = rest
//   beat_tick   out  1   one-cycle pulse per beat
//   note_valid  out  1   one-cycle pulse: a non-rest note is released
//   note_code   out  8   released code; valid when note_valid
//   note_lane   out  2   note_code[3:2]; valid when note_valid
//   fill_level  out  clog2(DEPTH+1)   current FIFO occupancy
// BEHAVIOUR
//   Reset: resetn sampled low at a clock edge clears everything at that edge.
//     - beat_cnt, FIFO pointers and count are cleared.
//     - beat_tick, note_valid, note_code, note_lane and fill_level are all 0.
//   Beat timer:
//     - beat_cnt counts 0..BEAT_CYCLES-1 while run=1, then wraps to 0.
//     - tick = run && (beat_cnt == BEAT_CYCLES-1).
//   On each tick edge:
//     - push: data if data_en=1, else 8'd0 (rest). Exactly one entry per beat keeps the delay aligned.
//     - pop: the head entry, if the count before the push equals LEAD_BEATS.
//     - Push and pop in the same edge are legal: count stays LEAD_BEATS, head advances.
//     - Steady-state occupancy is LEAD_BEATS, so overflow cannot occur when DEPTH is legal.
//   Outputs (registered):
//     - beat_tick = 1 for the cycle after every tick edge.
//     - If a popped code is non-zero: note_valid=1 and note_code/note_lane are loaded for the same cycle.
//     - If the popped code is zero (rest): note_valid stays 0.
//     - note_code/note_lane hold their last value when note_valid=0.
//   Latency: a code sampled at tick k is emitted on tick k+LEAD_BEATS, i.e. LEAD_BEATS*BEAT_CYCLES clocks later.
//   Warm-up: the first LEAD_BEATS ticks after run rises only push. No note_valid during warm-up.
//   run=0 (any time, including mid-beat):
//     - beat_cnt is cleared and the FIFO is flushed at the next edge; fill_level=0 after that edge.
//     - beat_tick and note_valid are forced to 0.
//     - Re-asserting run restarts warm-up from beat_cnt=0.
//   data changing between ticks is ignored; only the tick-edge value is sampled.
//   Arithmetic:
//     - beat_cnt width is clog2(BEAT_CYCLES).
//     - The count compare is unsigned against LEAD_BEATS.
//     - Pointers wrap modulo DEPTH (DEPTH need not be a power of two; explicit wrap at DEPTH-1).
// STRUCTURE
//   Shared package beatmap_pkg:
//     - REST_CODE = 8'd0
//     - LANE_MSB = 3, LANE_LSB = 2
//     - typedef note_code_t (8-bit)
//   Sub-module beat_fifo: synchronous FIFO.
//     - Interface: push/pop/flush/din/dout/count; parameter DEPTH.
//     - Same clk/resetn convention as this block.
//   Top level: beat timer, push/pop control, output registers.
// TESTING (BEAT_CYCLES=4, LEAD_BEATS=2, DEPTH=4 unless noted)
//   1. resetn=0 for 2 clks, run=1 -> all outputs 0; beat_tick first at clk 4 after release.
//   2. data_en=1, codes 140,144,148,152 on ticks 1-4 -> note_valid at ticks 3,4,5,6.
//      Codes 140/lane3, 144/lane0, 148/lane1, 152/lane2; fill_level settles at 2.
//   3. data_en=0 on tick 2 -> no note_valid after tick 4; tick-3 code still emitted after tick 5.
//   4. data=8'd0 with data_en=1 -> treated as rest; no note_valid.
//   5. run=0 mid-beat with fill_level=2 -> next edge: fill_level=0, beat_cnt=0.
//      After run=1: no notes for 2 ticks.
//   6. resetn=0 for 1 clk mid-stream -> next edge: all outputs 0; warm-up restarts.
//      Also check BEAT_CYCLES=2, LEAD_BEATS=3: steady-state pop+push keeps fill_level=3.

Source files
------------

// File: rtl/beatmap_pkg.sv
// Shared types and constants for the beatmap note path.
package beatmap_pkg;

   typedef logic [7:0] note_code_t;

   localparam note_code_t REST_CODE = 8'd0;
   localparam int         LANE_MSB  = 3;
   localparam int         LANE_LSB  = 2;

   function automatic logic [1:0] lane_of(input note_code_t code);
      return code[LANE_MSB:LANE_LSB];
   endfunction

endpackage

// File: rtl/beat_fifo.sv
// Synchronous delay FIFO holding one note code per beat; pointers wrap explicitly at DEPTH-1.
module beat_fifo
   import beatmap_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  note_code_t                 din,
   output note_code_t                 dout,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   note_code_t    mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A full FIFO still accepts a push when the same edge pops.
   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

   always_comb begin
      wr_ptr_d = do_push ? ptr_next(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (resetn && !flush && do_push) begin
         mem[wr_ptr_q] <= din;
      end
   end

   assign dout  = mem[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/beat_note_scheduler.sv
// Samples one generator code per beat and releases it LEAD_BEATS beats later as a note event.
module beat_note_scheduler
   import beatmap_pkg::*;
#(
   parameter int BEAT_CYCLES = 50_000_000,
   parameter int LEAD_BEATS  = 4,
   parameter int DEPTH       = 8
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       run,
   input  logic                       data_en,
   input  logic [7:0]                 data,
   output logic                       beat_tick,
   output logic                       note_valid,
   output logic [7:0]                 note_code,
   output logic [1:0]                 note_lane,
   output logic [$clog2(DEPTH+1)-1:0] fill_level
);

   localparam int BW = $clog2(BEAT_CYCLES);
   localparam int FW = $clog2(DEPTH + 1);

   logic [BW-1:0] beat_cnt_q, beat_cnt_d;
   logic          beat_tick_q;
   logic          note_valid_q, note_valid_d;
   note_code_t    note_code_q;
   logic [1:0]    note_lane_q;

   logic          tick;
   logic          pop;
   note_code_t    push_din;
   note_code_t    head;
   logic [FW-1:0] count;

   assign tick     = run && (beat_cnt_q == BW'(BEAT_CYCLES - 1));
   assign push_din = data_en ? note_code_t'(data) : REST_CODE;
   // Occupancy is checked before this edge's push, so steady state pops and pushes together.
   assign pop      = tick && (count == FW'(LEAD_BEATS));

   always_comb begin
      beat_cnt_d   = tick ? '0 : beat_cnt_q + BW'(1);
      note_valid_d = pop && (head != REST_CODE);
   end

   beat_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (tick),
      .pop    (pop),
      .flush  (!run),
      .din    (push_din),
      .dout   (head),
      .count  (count)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         beat_cnt_q   <= '0;
         beat_tick_q  <= 1'b0;
         note_valid_q <= 1'b0;
         note_code_q  <= REST_CODE;
         note_lane_q  <= 2'd0;
      end else if (!run) begin
         beat_cnt_q   <= '0;
         beat_tick_q  <= 1'b0;
         note_valid_q <= 1'b0;
      end else begin
         beat_cnt_q   <= beat_cnt_d;
         beat_tick_q  <= tick;
         note_valid_q <= note_valid_d;
         if (note_valid_d) begin
            note_code_q <= head;
            note_lane_q <= lane_of(head);
         end
      end
   end

   assign beat_tick  = beat_tick_q;
   assign note_valid = note_valid_q;
   assign note_code  = note_code_q;
   assign note_lane  = note_lane_q;
   assign fill_level = count;

endmodule
